rgb_word_serializer: RTL

Parallel-to-serial transmitter for the RGB bit-stream path. It accepts one WIDTH-bit colour word over a valid/ready handshake and emits it MSB-first as a sequence of symbol codes. The symbol encoding is 2'b01 for a "0" bit, 2'b10 for a "1" bit and 2'b00 for hold, preceded by a one-cycle clear strobe. This encoding drives the q24 shift-in accumulator on the receive side directly, so a frame emitted here rebuilds the same word there.

---
 rtl/rgb_pkg.sv | 7 +
 rtl/rgb_slot_counter.sv | 20 ++
 rtl/rgb_word_serializer.sv | 67 ++++++
 3 files changed

// File: rtl/rgb_pkg.sv
// rgb_pkg: symbol codes shared with the receive-side accumulator and the serializer state type
package rgb_pkg;
    localparam logic [1:0] SYM_HOLD = 2'b00;
    localparam logic [1:0] SYM_ZERO = 2'b01;
    localparam logic [1:0] SYM_ONE  = 2'b10;
    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} ser_state_t;
endpackage

// File: rtl/rgb_slot_counter.sv
// rgb_slot_counter: modulo-N slot counter with wrap output and synchronous clear
module rgb_slot_counter #(
    parameter int N = 1,
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] cnt_o,
    output logic          wrap_o
);
    logic [CW-1:0] cnt_q;
    assign wrap_o = en_i && (cnt_q == CW'(N - 1));
    assign cnt_o  = cnt_q;
    always_ff @(posedge clk) begin
        if (rst || clr_i) cnt_q <= '0;
        else if (en_i) cnt_q <= wrap_o ? '0 : cnt_q + CW'(1);
    end
endmodule

// File: rtl/rgb_word_serializer.sv
// rgb_word_serializer: sends one colour word MSB-first as clr strobe + 01/10 symbol codes
module rgb_word_serializer
    import rgb_pkg::*;
#(
    parameter int WIDTH      = 24,
    parameter int BIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             clr,
    output logic [1:0]       sym,
    output logic             done
);
    localparam int BW = $clog2(WIDTH);
    localparam int SW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    ser_state_t       state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [BW-1:0]    bit_cnt_q;
    logic [SW-1:0]    slot_cnt;
    logic             wrap, clr_q, done_q;
    rgb_slot_counter #(.N(BIT_CYCLES)) u_slot (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q == IDLE),
        .en_i   (state_q == SHIFT),
        .cnt_o  (slot_cnt),
        .wrap_o (wrap)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            clr_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            clr_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (in_valid) begin
                    shreg_q   <= data_in;
                    bit_cnt_q <= BW'(WIDTH - 1);
                    clr_q     <= 1'b1;
                    state_q   <= CLEAR;
                end
                CLEAR: state_q <= SHIFT;
                SHIFT: if (wrap) begin
                    shreg_q   <= {shreg_q[WIDTH-2:0], 1'b0};
                    bit_cnt_q <= bit_cnt_q - 1'b1;
                    if (bit_cnt_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign in_ready = (state_q == IDLE) && !rst;
    assign sym = (state_q == SHIFT && slot_cnt == '0) ? (shreg_q[WIDTH-1] ? SYM_ONE : SYM_ZERO) : SYM_HOLD;
    assign clr  = clr_q;
    assign done = done_q;
endmodule
